// File: rtl/ecc_hamming_secded_faulty_memory.sv
// 16 x 8-bit memory stored as extended Hamming (13,8) SECDED codewords, with a
// combinational decode path and a read-side fault injector that never alters storage.
module ecc_hamming_secded_faulty_memory (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] input_data,
  input  logic [3:0] input_addr,
  input  logic       wr_en,
  input  logic [3:0] fault_addr1,
  input  logic [3:0] fault_addr2,
  input  logic       fault_enable,
  input  logic       two_bit_fault_enable,
  output logic [7:0] output_data,
  output logic       single_bit_error_corrected,
  output logic       double_bit_error_detected
);

  // Data bits live at codeword positions 3,5,6,7,9,10,11,12; parity at 1,2,4,8; overall at 0.
  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] c;
    c       = 13'h0000;
    c[3]    = d[0];
    c[5]    = d[1];
    c[6]    = d[2];
    c[7]    = d[3];
    c[9]    = d[4];
    c[10]   = d[5];
    c[11]   = d[6];
    c[12]   = d[7];
    c[1]    = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[2]    = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[4]    = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[8]    = d[4] ^ d[5] ^ d[6] ^ d[7];
    c[0]    = ^c[12:1];
    return c;
  endfunction

  function automatic logic [7:0] extract_data(input logic [12:0] c);
    return {c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]};
  endfunction

  function automatic logic [3:0] syndrome(input logic [12:0] c);
    logic [3:0] s;
    s = 4'h0;
    for (int i = 1; i < 13; i++) begin
      if (c[i]) begin
        s = s ^ 4'(i);
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  function automatic logic [12:0] fault_bit(input logic en, input logic [3:0] idx);
    logic [12:0] m;
    if (en && (idx <= 4'd12)) begin
      m = 13'h0001 << idx;
    end else begin
      m = 13'h0000;
    end
    return m;
  endfunction

  logic [12:0] mem_q [16];
  logic [12:0] wr_word_d;
  logic [12:0] fault_mask_d;
  logic [12:0] rx_d;
  logic [12:0] fixed_d;
  logic [3:0]  syn_d;
  logic        par_d;

  assign wr_word_d = encode(input_data);

  // Codeword storage; reset clears every entry to the all-zero valid codeword.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 13'h0000;
      end
    end else if (wr_en) begin
      mem_q[input_addr] <= wr_word_d;
    end else begin
      mem_q[input_addr] <= mem_q[input_addr];
    end
  end

  // Read path: apply the injected fault mask, then classify and correct.
  always_comb begin
    fault_mask_d = fault_bit(fault_enable, fault_addr1)
                 | fault_bit(fault_enable & two_bit_fault_enable, fault_addr2);
    rx_d         = mem_q[input_addr] ^ fault_mask_d;
    syn_d        = syndrome(rx_d);
    par_d        = ^rx_d;
    fixed_d      = rx_d;
    single_bit_error_corrected = 1'b0;
    double_bit_error_detected  = 1'b0;
    if (!par_d) begin
      if (syn_d == 4'h0) begin
        fixed_d = rx_d;
      end else begin
        double_bit_error_detected = 1'b1;
      end
    end else begin
      if (syn_d == 4'h0) begin
        single_bit_error_corrected = 1'b1;
      end else if (syn_d <= 4'd12) begin
        fixed_d = rx_d ^ (13'h0001 << syn_d);
        single_bit_error_corrected = 1'b1;
      end else begin
        // A nonexistent position can only come from multiple flips.
        double_bit_error_detected = 1'b1;
      end
    end
    output_data = extract_data(fixed_d);
  end

endmodule

// File: tb/tb_ecc_hamming_secded_faulty_memory.sv
// Directed bench for the SECDED faulty memory: expected read results are queued
// when a read is driven and popped and checked once the outputs settle.
module tb_ecc_hamming_secded_faulty_memory;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] input_data = 8'h00;
  logic [3:0] input_addr = 4'h0;
  logic       wr_en = 1'b0;
  logic [3:0] fault_addr1 = 4'h0;
  logic [3:0] fault_addr2 = 4'h0;
  logic       fault_enable = 1'b0;
  logic       two_bit_fault_enable = 1'b0;
  logic [7:0] output_data;
  logic       single_bit_error_corrected;
  logic       double_bit_error_detected;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d;
    logic       c;
    logic       x;
    string      tag;
  } exp_t;
  exp_t sb[$];

  ecc_hamming_secded_faulty_memory dut (
    .clk(clk), .rst(rst), .input_data(input_data), .input_addr(input_addr),
    .wr_en(wr_en), .fault_addr1(fault_addr1), .fault_addr2(fault_addr2),
    .fault_enable(fault_enable), .two_bit_fault_enable(two_bit_fault_enable),
    .output_data(output_data),
    .single_bit_error_corrected(single_bit_error_corrected),
    .double_bit_error_detected(double_bit_error_detected)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  // Data bits of a fault mask, i.e. which data bits a raw read would see flipped.
  function automatic logic [7:0] dmask(input logic [12:0] m);
    return {m[12], m[11], m[10], m[9], m[7], m[6], m[5], m[3]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic c, input logic x, input string tag);
    exp_t e;
    e.d = d; e.c = c; e.x = x; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty obs=0 exp=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_data"}, output_data, e.d);
      chk({e.tag, "_corr"}, {7'h00, single_bit_error_corrected}, {7'h00, e.c});
      chk({e.tag, "_dbl"},  {7'h00, double_bit_error_detected},  {7'h00, e.x});
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic fe, input logic tb2,
                    input logic [3:0] f1, input logic [3:0] f2,
                    input logic [7:0] ed, input logic ec, input logic ex, input string tag);
    @(negedge clk);
    input_addr = a; fault_enable = fe; two_bit_fault_enable = tb2;
    fault_addr1 = f1; fault_addr2 = f2;
    push(ed, ec, ex, tag);
    #1;
    pop_check();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    input_addr = a; input_data = d; wr_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  logic [7:0] pat [8] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h1E, 8'hB4};

  initial begin
    logic [12:0] m;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++)
      rd(4'(i), 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, $sformatf("reset_a%0d", i));

    for (int i = 0; i < 8; i++) wr(4'(i), pat[i]);
    for (int i = 0; i < 8; i++)
      rd(4'(i), 1'b0, 1'b0, 4'h0, 4'h0, pat[i], 1'b0, 1'b0, $sformatf("clean_a%0d", i));

    for (int b = 0; b < 13; b++)
      rd(4'h0, 1'b1, 1'b0, 4'(b), 4'h0, 8'hA5, 1'b1, 1'b0, $sformatf("single_b%0d", b));

    rd(4'h0, 1'b1, 1'b1, 4'd3, 4'd5, 8'hA6, 1'b0, 1'b1, "double_3_5");
    // Two-bit mode without fault_enable injects nothing.
    rd(4'h0, 1'b0, 1'b1, 4'd3, 4'd5, 8'hA5, 1'b0, 1'b0, "fault_disabled");

    for (int i = 0; i < 13; i++) begin
      for (int j = i + 1; j < 13; j++) begin
        m = (13'h0001 << i) | (13'h0001 << j);
        rd(4'h1, 1'b1, 1'b1, 4'(i), 4'(j), 8'h3C ^ dmask(m), 1'b0, 1'b1,
           $sformatf("pair_%0d_%0d", i, j));
      end
    end

    for (int b = 13; b < 16; b++)
      rd(4'h2, 1'b1, 1'b0, 4'(b), 4'h0, 8'hFF, 1'b0, 1'b0, $sformatf("oor_b%0d", b));
    rd(4'h4, 1'b1, 1'b1, 4'd14, 4'd4, 8'h5A, 1'b1, 1'b0, "oor_plus_single");
    rd(4'h0, 1'b1, 1'b1, 4'd7, 4'd7, 8'hA5, 1'b1, 1'b0, "same_addr_7");
    rd(4'h5, 1'b1, 1'b1, 4'd9, 4'd9, 8'hC3, 1'b1, 1'b0, "same_addr_9");

    // Write while a fault is active; the stored word must stay clean.
    @(negedge clk);
    fault_enable = 1'b1; two_bit_fault_enable = 1'b0; fault_addr1 = 4'd2;
    wr(4'h8, 8'h77);
    rd(4'h8, 1'b1, 1'b0, 4'd2, 4'h0, 8'h77, 1'b1, 1'b0, "wr_fault_on");
    rd(4'h8, 1'b0, 1'b0, 4'd2, 4'h0, 8'h77, 1'b0, 1'b0, "wr_fault_off");

    // Same-address write and read: old word before the edge, new word after.
    @(negedge clk);
    input_addr = 4'h3; input_data = 8'h99; wr_en = 1'b1;
    push(8'h00, 1'b0, 1'b0, "rw_before");
    #1; pop_check();
    @(posedge clk);
    push(8'h99, 1'b0, 1'b0, "rw_after");
    #1; pop_check();
    @(negedge clk);
    wr_en = 1'b0;

    // Reset asserted during a pending write wins and clears the memory.
    @(negedge clk);
    input_addr = 4'h4; input_data = 8'h11; wr_en = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk);
    push(8'h00, 1'b0, 1'b0, "rst_mid_write");
    #1; pop_check();
    @(negedge clk);
    wr_en = 1'b0; rst = 1'b1;
    rd(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, "post_rst_a0");
    rd(4'h8, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, "post_rst_a8");
    wr(4'h4, 8'h11);
    rd(4'h4, 1'b0, 1'b0, 4'h0, 4'h0, 8'h11, 1'b0, 1'b0, "post_rst_wr");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover obs=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
